// File: rtl/alu_ctrl_fsm.sv
// alu_ctrl_fsm: multi-cycle instruction sequencer for the 16-bit datapath ALU.
// Fetches instructions over a req/valid handshake, decodes them into ALU
// select codes and register-file addresses, and updates the PC and a sticky
// overflow flag from the ALU's branch/overflow results.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | waiting for start; no fetch outstanding
// FETCH  | imem_req high at imem_addr=pc until imem_valid, then latch ir
// DECODE | one cycle for rf_ra1/rf_ra2 to settle; HALT opcode exits here
// EXEC   | one cycle: alu_s driven, rf_we pulsed for ALU ops, pc updated
// HALT   | frozen at the HALT instruction's pc; only reset leaves
//
// Instruction format: opcode=ir[15:12] ra=ir[11:9] rb=ir[8:6] rd=ir[5:3]
// imm6=ir[5:0] (signed, branches only). The branch offset is sign-extended
// to PC_W bits, so PC_W must be at least 6.

module alu_ctrl_fsm #(
   parameter int          PC_W     = 8,
   parameter int unsigned START_PC = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_valid,
   input  logic [15:0]     imem_rdata,
   output logic [2:0]      rf_ra1,
   output logic [2:0]      rf_ra2,
   output logic [2:0]      rf_wa,
   output logic            rf_we,
   output logic [3:0]      alu_s,
   input  logic            alu_ovf,
   input  logic            alu_take_branch,
   output logic [PC_W-1:0] pc,
   output logic            ovf_flag,
   output logic            halted,
   output logic            busy
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_HALT   = 3'd4
   } state_t;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_NOT  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_SRA  = 4'b0100;
   localparam logic [3:0] OP_SLL  = 4'b0101;
   localparam logic [3:0] OP_BEQZ = 4'b0110;
   localparam logic [3:0] OP_BNEZ = 4'b0111;
   localparam logic [3:0] OP_XOR  = 4'b1000;
   localparam logic [3:0] OP_HALT = 4'b1111;

   state_t          r_state;
   logic [PC_W-1:0] r_pc;
   logic [15:0]     r_ir;
   logic            r_ovf;

   state_t          w_state_nxt;
   logic [PC_W-1:0] w_pc_nxt;
   logic [15:0]     w_ir_nxt;
   logic            w_ovf_nxt;

   logic [3:0]      w_opcode;
   logic            w_is_alu;
   logic            w_is_branch;
   logic            w_is_halt;
   logic [PC_W-1:0] w_pc_inc;
   logic [PC_W-1:0] w_imm_ext;

   assign w_opcode    = r_ir[15:12];
   assign w_pc_inc    = r_pc + PC_W'(1);
   assign w_imm_ext   = PC_W'($signed(r_ir[5:0]));
   assign w_is_branch = (w_opcode == OP_BEQZ) || (w_opcode == OP_BNEZ);
   assign w_is_halt   = (w_opcode == OP_HALT);

   // Opcode class decode; anything not listed is a NOP.
   always_comb begin
      w_is_alu = 1'b0;
      case (w_opcode)
         OP_ADD, OP_NOT, OP_AND, OP_OR,
         OP_SRA, OP_SLL, OP_XOR: w_is_alu = 1'b1;
         default:                w_is_alu = 1'b0;
      endcase
   end

   // Register-file addresses follow ir directly so operands settle in DECODE.
   assign rf_ra1    = r_ir[11:9];
   assign rf_ra2    = r_ir[8:6];
   assign rf_wa     = r_ir[5:3];
   assign imem_addr = r_pc;
   assign pc        = r_pc;
   assign ovf_flag  = r_ovf;

   // State register and architectural state, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_pc    <= PC_W'(START_PC);
         r_ir    <= '0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_ir    <= w_ir_nxt;
         r_ovf   <= w_ovf_nxt;
      end
   end

   // Next-state, PC/IR/flag update and Moore-style control outputs.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_ir_nxt    = r_ir;
      w_ovf_nxt   = r_ovf;
      imem_req    = 1'b0;
      rf_we       = 1'b0;
      alu_s       = 4'b0000;
      halted      = 1'b0;
      busy        = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (start) w_state_nxt = S_FETCH;
         end

         S_FETCH: begin
            busy     = 1'b1;
            imem_req = 1'b1;
            if (imem_valid) begin
               w_ir_nxt    = imem_rdata;
               w_state_nxt = S_DECODE;
            end
         end

         S_DECODE: begin
            busy        = 1'b1;
            w_state_nxt = w_is_halt ? S_HALT : S_EXEC;
         end

         S_EXEC: begin
            busy        = 1'b1;
            w_state_nxt = S_FETCH;
            w_pc_nxt    = w_pc_inc;
            if (w_is_alu) begin
               alu_s = w_opcode;
               rf_we = 1'b1;
               // Overflow is only meaningful for ADD; other ops may raise alu_ovf.
               if ((w_opcode == OP_ADD) && alu_ovf) w_ovf_nxt = 1'b1;
            end else if (w_is_branch) begin
               alu_s = w_opcode;
               if (alu_take_branch) w_pc_nxt = w_pc_inc + w_imm_ext;
            end
         end

         S_HALT: begin
            halted = 1'b1;
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Directed bench for alu_ctrl_fsm: a behavioural instruction memory answers
// fetches (zero-wait or manually delayed), expected values are hand-derived.
module tb_alu_ctrl_fsm;

   localparam int PC_W = 8;

   logic            clk = 1'b0;
   logic            rst, start, imem_req, imem_valid, rf_we;
   logic            alu_ovf, alu_take_branch, ovf_flag, halted, busy;
   logic [PC_W-1:0] imem_addr, pc;
   logic [15:0]     imem_rdata;
   logic [2:0]      rf_ra1, rf_ra2, rf_wa;
   logic [3:0]      alu_s;

   logic [15:0]     mem [0:255];
   logic            manual_valid, valid_drv;
   int              n_cmp = 0;
   int              n_err = 0;
   int              we_count = 0;

   alu_ctrl_fsm #(.PC_W(PC_W), .START_PC(0)) dut (
      .clk(clk), .rst(rst), .start(start),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid),
      .imem_rdata(imem_rdata), .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_wa(rf_wa),
      .rf_we(rf_we), .alu_s(alu_s), .alu_ovf(alu_ovf),
      .alu_take_branch(alu_take_branch), .pc(pc), .ovf_flag(ovf_flag),
      .halted(halted), .busy(busy)
   );

   always #5 clk = ~clk;

   assign imem_rdata = mem[imem_addr];
   assign imem_valid = manual_valid ? valid_drv : imem_req;

   // rf_we as seen by the register file at each rising edge
   always @(posedge clk) if (rf_we === 1'b1) we_count++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic fill_nops();
      for (int i = 0; i < 256; i++) mem[i] = 16'h9000;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1; start = 1'b0; manual_valid = 1'b0; valid_drv = 1'b0;
      alu_ovf = 1'b0; alu_take_branch = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      we_count = 0;
   endtask

   task automatic go();
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst0_busy got %b want 0", busy); end
      n_cmp++; if (pc !== 8'd0) begin n_err++; $display("FAIL rst0_pc got %0d want 0", pc); end
      fill_nops();
      apply_reset();
      n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req got %b want 0", imem_req); end
      n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL rst_we got %b want 0", rf_we); end
      n_cmp++; if (alu_s !== 4'h0) begin n_err++; $display("FAIL rst_alu_s got %h want 0", alu_s); end
      n_cmp++; if (ovf_flag !== 1'b0) begin n_err++; $display("FAIL rst_ovf got %b want 0", ovf_flag); end
      n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL rst_halted got %b want 0", halted); end
      n_cmp++; if (rf_wa !== 3'd0) begin n_err++; $display("FAIL rst_wa got %0d want 0", rf_wa); end
      step(3);
      n_cmp++; if (busy !== 1'b0 || imem_req !== 1'b0) begin n_err++; $display("FAIL idle_hold busy=%b req=%b want 0 0", busy, imem_req); end
   endtask

   task automatic test_add();
      fill_nops();
      mem[0] = 16'h0258;
      mem[1] = 16'h3258;
      apply_reset();
      go();
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 8'd0 || busy !== 1'b1) begin n_err++; $display("FAIL add_fetch req=%b addr=%0d busy=%b want 1 0 1", imem_req, imem_addr, busy); end
      step(1);
      n_cmp++; if (rf_ra1 !== 3'd1 || rf_ra2 !== 3'd1 || busy !== 1'b1) begin n_err++; $display("FAIL add_decode ra1=%0d ra2=%0d busy=%b want 1 1 1", rf_ra1, rf_ra2, busy); end
      n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL add_decode_we got %b want 0", rf_we); end
      step(1);
      n_cmp++; if (alu_s !== 4'h0 || rf_we !== 1'b1 || rf_wa !== 3'd3 || busy !== 1'b1) begin n_err++; $display("FAIL add_exec alu_s=%h we=%b wa=%0d busy=%b want 0 1 3 1", alu_s, rf_we, rf_wa, busy); end
      step(1);
      n_cmp++; if (pc !== 8'd1 || rf_we !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL add_done pc=%0d we=%b busy=%b want 1 0 1", pc, rf_we, busy); end
      n_cmp++; if (we_count !== 1) begin n_err++; $display("FAIL add_we_count got %0d want 1", we_count); end
      step(2);
      n_cmp++; if (alu_s !== 4'h3 || rf_we !== 1'b1) begin n_err++; $display("FAIL or_exec alu_s=%h we=%b want 3 1", alu_s, rf_we); end
   endtask

   task automatic test_branch(input logic take, input logic [7:0] exp_pc);
      fill_nops();
      mem[5] = 16'h61FE;
      apply_reset();
      alu_take_branch = take;
      go();
      step(15);
      n_cmp++; if (pc !== 8'd5) begin n_err++; $display("FAIL br_pre_pc take=%b got %0d want 5", take, pc); end
      step(2);
      n_cmp++; if (alu_s !== 4'h6 || rf_we !== 1'b0) begin n_err++; $display("FAIL br_exec take=%b alu_s=%h we=%b want 6 0", take, alu_s, rf_we); end
      step(1);
      n_cmp++; if (pc !== exp_pc) begin n_err++; $display("FAIL br_pc take=%b got %0d want %0d", take, pc, exp_pc); end
      n_cmp++; if (we_count !== 0) begin n_err++; $display("FAIL br_we_count take=%b got %0d want 0", take, we_count); end
   endtask

   task automatic test_wrap();
      fill_nops();
      mem[0] = 16'h61FE;
      apply_reset();
      alu_take_branch = 1'b1;
      go();
      step(3);
      n_cmp++; if (pc !== 8'd255) begin n_err++; $display("FAIL wrap_neg got %0d want 255", pc); end
      step(3);
      n_cmp++; if (pc !== 8'd0) begin n_err++; $display("FAIL wrap_inc got %0d want 0", pc); end
   endtask

   task automatic test_ovf();
      fill_nops();
      mem[0] = 16'h8258;
      mem[1] = 16'h0258;
      mem[2] = 16'h8258;
      mem[3] = 16'hF000;
      apply_reset();
      alu_ovf = 1'b1;
      go();
      step(2);
      n_cmp++; if (alu_s !== 4'h8 || rf_we !== 1'b1) begin n_err++; $display("FAIL xor_exec alu_s=%h we=%b want 8 1", alu_s, rf_we); end
      step(1);
      n_cmp++; if (ovf_flag !== 1'b0) begin n_err++; $display("FAIL ovf_xor_first got %b want 0", ovf_flag); end
      step(2);
      n_cmp++; if (ovf_flag !== 1'b0) begin n_err++; $display("FAIL ovf_add_exec got %b want 0", ovf_flag); end
      step(1);
      n_cmp++; if (ovf_flag !== 1'b1) begin n_err++; $display("FAIL ovf_add_set got %b want 1", ovf_flag); end
      alu_ovf = 1'b0;
      step(3);
      n_cmp++; if (ovf_flag !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b want 1", ovf_flag); end
   endtask

   task automatic test_wait();
      fill_nops();
      mem[0] = 16'h1258;
      apply_reset();
      manual_valid = 1'b1;
      valid_drv = 1'b0;
      go();
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 8'd0 || busy !== 1'b1) begin n_err++; $display("FAIL wait_hold cyc=%0d req=%b addr=%0d busy=%b want 1 0 1", i, imem_req, imem_addr, busy); end
         step(1);
      end
      valid_drv = 1'b1;
      step(1);
      n_cmp++; if (imem_req !== 1'b0 || pc !== 8'd0) begin n_err++; $display("FAIL wait_decode req=%b pc=%0d want 0 0", imem_req, pc); end
      step(1);
      n_cmp++; if (alu_s !== 4'h1 || rf_we !== 1'b1) begin n_err++; $display("FAIL wait_exec alu_s=%h we=%b want 1 1", alu_s, rf_we); end
      step(1);
      n_cmp++; if (pc !== 8'd1) begin n_err++; $display("FAIL wait_done pc got %0d want 1", pc); end
      manual_valid = 1'b0;
   endtask

   task automatic test_halt();
      fill_nops();
      mem[7] = 16'hF000;
      apply_reset();
      go();
      step(21);
      n_cmp++; if (pc !== 8'd7) begin n_err++; $display("FAIL halt_pre_pc got %0d want 7", pc); end
      step(2);
      n_cmp++; if (halted !== 1'b1 || busy !== 1'b0 || pc !== 8'd7 || imem_req !== 1'b0) begin n_err++; $display("FAIL halt_enter halted=%b busy=%b pc=%0d req=%b want 1 0 7 0", halted, busy, pc, imem_req); end
      start = 1'b1;
      step(2);
      start = 1'b0;
      step(3);
      n_cmp++; if (halted !== 1'b1 || busy !== 1'b0 || pc !== 8'd7 || imem_req !== 1'b0) begin n_err++; $display("FAIL halt_start_ign halted=%b busy=%b pc=%0d req=%b want 1 0 7 0", halted, busy, pc, imem_req); end
      n_cmp++; if (we_count !== 0) begin n_err++; $display("FAIL halt_we_count got %0d want 0", we_count); end
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (halted !== 1'b0 || pc !== 8'd0 || busy !== 1'b0) begin n_err++; $display("FAIL halt_rst halted=%b pc=%0d busy=%b want 0 0 0", halted, pc, busy); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_async_reset();
      fill_nops();
      mem[1] = 16'h3258;
      apply_reset();
      go();
      step(3);
      manual_valid = 1'b1;
      valid_drv = 1'b0;
      step(1);
      n_cmp++; if (pc !== 8'd1 || imem_req !== 1'b1) begin n_err++; $display("FAIL arst_fetch_pre pc=%0d req=%b want 1 1", pc, imem_req); end
      #3 rst = 1'b1;
      #1;
      n_cmp++; if (imem_req !== 1'b0 || busy !== 1'b0 || pc !== 8'd0) begin n_err++; $display("FAIL arst_fetch req=%b busy=%b pc=%0d want 0 0 0", imem_req, busy, pc); end
      @(negedge clk);
      rst = 1'b0;
      manual_valid = 1'b0;
      we_count = 0;
      go();
      step(3);
      step(2);
      n_cmp++; if (rf_we !== 1'b1 || alu_s !== 4'h3 || pc !== 8'd1) begin n_err++; $display("FAIL arst_exec_pre we=%b alu_s=%h pc=%0d want 1 3 1", rf_we, alu_s, pc); end
      #3 rst = 1'b1;
      #1;
      n_cmp++; if (rf_we !== 1'b0 || alu_s !== 4'h0 || pc !== 8'd0 || busy !== 1'b0) begin n_err++; $display("FAIL arst_exec we=%b alu_s=%h pc=%0d busy=%b want 0 0 0 0", rf_we, alu_s, pc, busy); end
      @(posedge clk);
      #1;
      n_cmp++; if (we_count !== 0) begin n_err++; $display("FAIL arst_we_count got %0d want 0", we_count); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; manual_valid = 1'b0; valid_drv = 1'b0;
      alu_ovf = 1'b0; alu_take_branch = 1'b0;
      test_reset();
      test_add();
      test_branch(1'b1, 8'd4);
      test_branch(1'b0, 8'd6);
      test_wrap();
      test_ovf();
      test_wait();
      test_halt();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/alu_ctrl_fsm.md
Name: alu_ctrl_fsm

Overview:
- Multi-cycle control sequencer that drives the 16-bit datapath ALU from the instruction side.
- Fetches 16-bit instructions over a req/valid handshake and decodes them into ALU select codes and register-file addresses/write enable.
- Consumes the ALU's take_branch and ovf outputs to update the PC and a sticky overflow flag.
- Sits between instruction memory and the register file/ALU datapath.

Parameters:
- PC_W, 8, program counter width in bits; PC wraps modulo 2^PC_W.
- START_PC, 0, PC value loaded at reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begins execution from IDLE; ignored in other states.
- imem_req  out  1  instruction fetch request, held until imem_valid.
- imem_addr  out  PC_W  fetch address, equal to pc.
- imem_valid  in  1  imem_rdata valid this cycle; meaningful only while imem_req=1.
- imem_rdata  in  16  fetched instruction.
- rf_ra1  out  3  register read address for ALU operand a, = ir[11:9].
- rf_ra2  out  3  register read address for ALU operand b, = ir[8:6].
- rf_wa  out  3  register write address, = ir[5:3].
- rf_we  out  1  register write enable, single-cycle pulse.
- alu_s  out  4  ALU select code.
- alu_ovf  in  1  ALU overflow flag.
- alu_take_branch  in  1  ALU branch decision.
- pc  out  PC_W  current program counter.
- ovf_flag  out  1  sticky overflow indicator.
- halted  out  1  high while in HALT.
- busy  out  1  high in FETCH/DECODE/EXEC.

Behaviour:
- Reset (async, any state, mid-fetch included) sets:
  - state=IDLE, pc=START_PC, ir=0.
  - imem_req=0, rf_we=0, alu_s=0, ovf_flag=0, halted=0, busy=0.
  - Any in-flight fetch is abandoned.
- Instruction format:
  - opcode=ir[15:12], ra=ir[11:9], rb=ir[8:6], rd=ir[5:3], imm6=ir[5:0] (signed, branches only).
- Opcode classes:
  - ALU ops: 0000 ADD, 0001 NOT, 0010 AND, 0011 OR, 0100 SRA, 0101 SLL, 1000 XOR. These write the result to rd.
  - Branches: 0110 BEQZ, 0111 BNEZ. No register write.
  - 1111 HALT.
  - All other opcodes (1001-1110) are NOPs: alu_s=0000, rf_we=0, pc+1.
- States and transitions:
  - IDLE: start=1 -> FETCH.
  - FETCH: imem_req=1, imem_addr=pc. On imem_valid=1, latch ir=imem_rdata -> DECODE. Otherwise remain in FETCH (zero-wait memory allowed).
  - DECODE: one cycle. rf_ra1/rf_ra2 driven from ir so operands settle. HALT opcode -> HALT; otherwise -> EXEC.
  - EXEC: one cycle. alu_s=opcode, or 0000 for NOP/illegal.
    - ALU op: rf_we=1 this cycle only; pc <= pc+1.
    - ADD with alu_ovf=1: ovf_flag <= 1.
    - Branch with alu_take_branch=1: pc <= pc+1+sext(imm6).
    - Branch with alu_take_branch=0: pc <= pc+1.
    - Then -> FETCH.
  - HALT: halted=1, imem_req=0. pc frozen at the HALT instruction's address. Leaves only by reset; start is ignored.
- alu_s is 0000 outside EXEC. rf_we is 1 only in EXEC for ALU ops.
- ovf_flag:
  - Set only by ADD overflow in EXEC; never cleared except by reset.
  - alu_ovf is ignored for non-ADD ops.
- PC arithmetic is modulo 2^PC_W:
  - pc=2^PC_W-1 increments to 0.
  - Negative offsets wrap below 0.
- Minimum latency is 3 cycles per instruction (FETCH with same-cycle valid, DECODE, EXEC). Each wait cycle on imem_valid adds one.
- busy=1 in FETCH, DECODE and EXEC; 0 in IDLE and HALT.

Test Plan:
- Reset, then start=1 with zero-wait memory returning 0x0000-class ADD (ir=0x0258: ra=1, rb=1, rd=3) -> on cycle 3 alu_s=0000, rf_we=1, rf_wa=3; pc 0->1; busy high throughout.
- BEQZ ir=0x61FE (imm6=-2) at pc=5 with alu_take_branch=1 -> pc=4, rf_we never asserted. Same instruction with take_branch=0 -> pc=6.
- ADD with alu_ovf=1, then XOR with alu_ovf=1 -> ovf_flag rises after the ADD EXEC and stays 1; the XOR neither sets nor clears it.
- imem_valid delayed 4 cycles -> imem_req held high and imem_addr stable for all 4 cycles; instruction completes 4 cycles later than the zero-wait case.
- HALT 0xF000 fetched at pc=7 -> halted=1, busy=0, pc=7, imem_req=0 indefinitely; start pulses ignored; rst returns to IDLE with pc=START_PC.
- rst asserted mid-FETCH and mid-EXEC, asynchronous to clk -> outputs at reset values immediately; no rf_we pulse emitted; pc=START_PC.
